// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller sitting in front of a word-addressed data memory.
//
// Build option: define DCACHE_STATS_EN to add load hit/miss counters
// (hit_count, miss_count, 16-bit, saturating).
//
// Ports
//   clk         system clock, rising-edge state updates
//   reset       asynchronous active-low reset
//   cpu_req     request strobe, sampled only in IDLE
//   cpu_we      1 = store, 0 = load
//   cpu_addr    word address (bits above ADDR_W ignored)
//   cpu_wdata   store data
//   cpu_rdata   load data, non-zero only with cpu_ready on a load
//   cpu_ready   one-cycle completion pulse
//   mem_addr    memory word address, zero-extended above ADDR_W
//   mem_wdata   memory write data
//   mem_wr_en   memory write enable (memory writes on the falling edge)
//   mem_rd_en   memory read enable
//   mem_rdata   memory read data, settles well within one clock
//   hit_count   (DCACHE_STATS_EN) counted load hits
//   miss_count  (DCACHE_STATS_EN) counted load misses
//
// state  | meaning
// IDLE   | waiting for cpu_req, outputs idle
// LOOKUP | tag compare; load hit completes here
// REFILL | one memory read per cycle, WORDS cycles
// WRITE  | single-cycle write-through, completes the store
module dcache_ctrl #(
   parameter int ADDR_W = 7,
   parameter int LINES  = 8,
   parameter int WORDS  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr_en,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int OFF_W = $clog2(WORDS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_REFILL = 2'd2;
   localparam logic [1:0] S_WRITE  = 2'd3;

   logic [1:0]        r_state;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [OFF_W-1:0]  r_cnt;
   logic [LINES-1:0]  r_valid;
   logic [TAG_W-1:0]  r_tag_arr  [LINES];
   logic [31:0]       r_data_arr [LINES*WORDS];

   logic [IDX_W-1:0]       w_idx;
   logic [OFF_W-1:0]       w_off;
   logic [TAG_W-1:0]       w_tag;
   logic                   w_hit;
   logic                   w_last;
   logic [IDX_W+OFF_W-1:0] w_rd_ptr;
   logic [IDX_W+OFF_W-1:0] w_fill_ptr;
   logic                   w_unused_addr;

   assign w_idx      = r_addr[OFF_W+IDX_W-1:OFF_W];
   assign w_off      = r_addr[OFF_W-1:0];
   assign w_tag      = r_addr[ADDR_W-1:OFF_W+IDX_W];
   assign w_hit      = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
   assign w_last     = (r_cnt == OFF_W'(WORDS-1));
   assign w_rd_ptr   = {w_idx, w_off};
   assign w_fill_ptr = {w_idx, r_cnt};

   // Upper address bits are deliberately ignored.
   assign w_unused_addr = ^cpu_addr[31:ADDR_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_valid <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_req) begin
                  r_we    <= cpu_we;
                  r_addr  <= cpu_addr[ADDR_W-1:0];
                  r_wdata <= cpu_wdata;
                  r_state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (r_we) begin
                  r_state <= S_WRITE;
               end else if (w_hit) begin
                  r_state <= S_IDLE;
               end else begin
                  // Invalidate up front so an aborted refill never leaves
                  // a half-filled line marked valid.
                  r_cnt          <= '0;
                  r_valid[w_idx] <= 1'b0;
                  r_state        <= S_REFILL;
               end
            end
            S_REFILL: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_valid[w_idx] <= 1'b1;
                  r_cnt          <= '0;
                  r_state        <= S_LOOKUP;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Tag and data arrays are not cleared by reset; validity lives in r_valid.
   always_ff @(posedge clk) begin
      if (r_state == S_REFILL) begin
         r_data_arr[w_fill_ptr] <= mem_rdata;
         if (w_last) begin
            r_tag_arr[w_idx] <= w_tag;
         end
      end
      if ((r_state == S_WRITE) && w_hit) begin
         r_data_arr[w_rd_ptr] <= r_wdata;
      end
   end

   always_comb begin
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wr_en = 1'b0;
      mem_rd_en = 1'b0;
      case (r_state)
         S_LOOKUP: begin
            if (!r_we && w_hit) begin
               cpu_ready = 1'b1;
               cpu_rdata = r_data_arr[w_rd_ptr];
            end
         end
         S_REFILL: begin
            mem_rd_en = 1'b1;
            mem_addr  = {{(32-ADDR_W){1'b0}}, w_tag, w_idx, r_cnt};
         end
         S_WRITE: begin
            mem_wr_en = 1'b1;
            mem_addr  = {{(32-ADDR_W){1'b0}}, r_addr};
            mem_wdata = r_wdata;
            cpu_ready = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] r_hit_cnt;
   logic [15:0] r_miss_cnt;
   logic        r_post_refill;

   // The LOOKUP that follows a refill always hits and belongs to the load
   // already counted as a miss, so it is skipped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hit_cnt     <= '0;
         r_miss_cnt    <= '0;
         r_post_refill <= 1'b0;
      end else begin
         if ((r_state == S_REFILL) && w_last) begin
            r_post_refill <= 1'b1;
         end else if (r_state == S_LOOKUP) begin
            r_post_refill <= 1'b0;
         end
         if ((r_state == S_LOOKUP) && !r_we && !r_post_refill) begin
            if (w_hit) begin
               if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
               if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
         end
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   dcache_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr_en (mem_wr_en),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   // Backing memory: combinational read, write on the falling edge.
   logic [31:0] mem [128];
   assign mem_rdata = mem[mem_addr[6:0]];
   always @(negedge clk) begin
      if (mem_wr_en) mem[mem_addr[6:0]] <= mem_wdata;
   end

   // Reference model: cache contents as plain arrays plus a memory image.
   logic [31:0] ref_mem [128];
   logic        m_valid [8];
   logic [1:0]  m_tag   [8];
   logic [31:0] m_data  [8][4];
   int          m_hits;
   int          m_misses;

   typedef struct packed {
      logic        ready;
      logic [31:0] rdata;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t idle_e;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_lat;
   logic [31:0] last_rdata;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   // Per-cycle output trace a request must produce, derived from the
   // hit/miss rules applied to the model state.
   function automatic void build_exp(logic we, logic [31:0] addr, logic [31:0] wd);
      logic [6:0] a;
      logic [2:0] idx;
      logic [1:0] tag;
      logic [1:0] off;
      logic       hit;
      exp_t       e;
      a   = addr[6:0];
      off = a[1:0];
      idx = a[4:2];
      tag = a[6:5];
      hit = m_valid[idx] && (m_tag[idx] == tag);
      e   = '0;
      if (!we) begin
         if (hit) m_hits++; else m_misses++;
         if (!hit) begin
            exp_q.push_back(idle_e);
            for (int k = 0; k < 4; k++) begin
               e = '0;
               e.rd = 1'b1;
               e.addr = {25'd0, tag, idx, k[1:0]};
               exp_q.push_back(e);
               m_data[idx][k] = ref_mem[{tag, idx, k[1:0]}];
            end
            m_valid[idx] = 1'b1;
            m_tag[idx] = tag;
         end
         e = '0;
         e.ready = 1'b1;
         e.rdata = m_data[idx][off];
         exp_q.push_back(e);
      end else begin
         exp_q.push_back(idle_e);
         e.ready = 1'b1;
         e.wr    = 1'b1;
         e.addr  = {25'd0, a};
         e.wdata = wd;
         exp_q.push_back(e);
         ref_mem[a] = wd;
         if (hit) m_data[idx][off] = wd;
      end
   endfunction

   // Single compare process: every falling edge, outputs must equal the
   // next expected trace entry, or the idle pattern when none is pending.
   always @(negedge clk) begin
      exp_t act;
      exp_t e;
      act = {cpu_ready, cpu_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata};
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cyc++;
         chk($sformatf("cycle%0d", cyc), 128'(act), 128'(e));
         if (e.ready && cpu_ready) begin
            last_lat   = cyc;
            last_rdata = cpu_rdata;
         end
      end else begin
         chk("idle", 128'(act), 128'(idle_e));
      end
   end

   task automatic launch(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      @(posedge clk);
      #1;
      cpu_req  = 1'b0;
      cyc      = 0;
      last_lat = 0;
      last_rdata = '0;
      build_exp(we, addr, wd);
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      int t;
      launch(we, addr, wd);
      t = 0;
      while (exp_q.size() > 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL timeout actual=%0d pending expected=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_hits = 0;
      m_misses = 0;
   endtask

   initial begin
      idle_e = '0;
      for (int i = 0; i < 128; i++) begin
         mem[i]     = 32'h1000_0000 | i;
         ref_mem[i] = 32'h1000_0000 | i;
      end
      model_reset();

      // Reset held 3 cycles, then 10 idle cycles checked by the compare process.
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_outs", {cpu_ready, cpu_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, '0);
      repeat (10) @(negedge clk);

      // Store miss: write-through only.
      do_req(1'b1, 32'h12, 32'hDEADBEEF);
      chk("lat_store", last_lat, 2);

      // Load miss: refill 0x10..0x13, stored value comes back.
      do_req(1'b0, 32'h12, 32'h0);
      chk("lat_miss", last_lat, 6);
      chk("rdata_12", last_rdata, 32'hDEADBEEF);

      do_req(1'b0, 32'h13, 32'h0);
      chk("lat_hit", last_lat, 1);
      chk("rdata_13", last_rdata, 32'h1000_0013);

      // Store hit updates the line.
      do_req(1'b1, 32'h11, 32'hA5A5A5A5);
      do_req(1'b0, 32'h11, 32'h0);
      chk("lat_hit_11", last_lat, 1);
      chk("rdata_11", last_rdata, 32'hA5A5A5A5);

      // Conflict eviction on index 4.
      do_req(1'b0, 32'h32, 32'h0);
      chk("rdata_32", last_rdata, 32'h1000_0032);
      do_req(1'b0, 32'h12, 32'h0);
      chk("lat_evict", last_lat, 6);

      // Store miss with upper address bits set: address truncated.
      do_req(1'b1, 32'h8000_0040, 32'h0123_4567);

`ifdef DCACHE_STATS_EN
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
      chk("hit_pin", m_hits, 2);
      chk("miss_pin", m_misses, 3);
`endif

      // Reset during the 2nd refill cycle.
      launch(1'b0, 32'h32, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      do_req(1'b0, 32'h12, 32'h0);
      chk("lat_after_abort", last_lat, 6);
      chk("rdata_after_abort", last_rdata, 32'hDEADBEEF);
      do_req(1'b0, 32'hFFFF_FF92, 32'h0);
      chk("lat_hi_addr", last_lat, 1);
      chk("rdata_hi_addr", last_rdata, 32'hDEADBEEF);
      do_req(1'b0, 32'h32, 32'h0);
      chk("lat_32_refill", last_lat, 6);

`ifdef DCACHE_STATS_EN
      chk("hit_count2", hit_count, m_hits);
      chk("miss_count2", miss_count, m_misses);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
